// File: rtl/knock_pkg.sv
// Shared header field layout and framer state encoding for the flit input path.
package knock_pkg;

  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_W   = 8;
  localparam int unsigned HDR_LEN_LSB  = 8;

  typedef enum logic {
    EXPECT_HDR = 1'b0,
    PAYLOAD    = 1'b1
  } framer_state_t;

endpackage

// File: rtl/flit_framer.sv
// Write-side framer: tracks packet boundaries and tags each accepted push as header or payload.
module flit_framer
  import knock_pkg::*;
#(
  parameter int unsigned ADD_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [ADD_WIDTH-1:0] length,
  output logic                 is_hdr
);

  framer_state_t        state_q, state_d;
  logic [ADD_WIDTH-1:0] rem_q, rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EXPECT_HDR;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    is_hdr  = (state_q == EXPECT_HDR);
    if (push) begin
      case (state_q)
        EXPECT_HDR: begin
          // A zero-length header is a complete packet on its own.
          if (length != '0) begin
            rem_d   = length;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          rem_d = rem_q - ADD_WIDTH'(1);
          if (rem_q == ADD_WIDTH'(1)) state_d = EXPECT_HDR;
        end
        default: state_d = EXPECT_HDR;
      endcase
    end
  end

endmodule

// File: rtl/flit_buffer.sv
// Circular flit FIFO with header tagging; presents the head flit and its decoded header fields.
module flit_buffer
  import knock_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned ADD_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [FLIT_WIDTH-1:0]      flit_i,
  input  logic                       pop_i,
  output logic [FLIT_WIDTH-1:0]      flit_o,
  output logic                       data_valid_o,
  output logic [ADD_WIDTH-1:0]       flit_length_o,
  output logic [7:0]                 flit_address_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FLIT_WIDTH:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push_acc, pop_acc, tag_hdr;
  logic [FLIT_WIDTH:0] head;

  assign empty_o  = (count == '0);
  assign full_o   = (count == CNT_W'(DEPTH));
  assign count_o  = count;
  // Acceptance uses registered full/empty, so a pop never frees room for a same-cycle push.
  assign push_acc = push_i & ~full_o;
  assign pop_acc  = pop_i & ~empty_o;

  flit_framer #(.ADD_WIDTH(ADD_WIDTH)) u_framer (
    .clk    (clk),
    .rst    (rst),
    .push   (push_acc),
    .length (flit_i[HDR_LEN_LSB +: ADD_WIDTH]),
    .is_hdr (tag_hdr)
  );

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= {tag_hdr, flit_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_i && full_o)  overflow_o  <= 1'b1;
      if (pop_i && empty_o)  underflow_o <= 1'b1;
    end
  end

  always_comb begin
    head           = empty_o ? '0 : mem[rd_ptr];
    flit_o         = head[FLIT_WIDTH-1:0];
    data_valid_o   = head[FLIT_WIDTH];
    flit_length_o  = head[HDR_LEN_LSB +: ADD_WIDTH];
    flit_address_o = head[HDR_ADDR_LSB +: HDR_ADDR_W];
  end

endmodule

// File: tb/tb_flit_buffer.sv
// Directed self-checking bench for flit_buffer with hand-computed expectations.
module tb_flit_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_i, pop_i;
  logic [31:0] flit_i;
  logic [31:0] flit_o;
  logic        data_valid_o;
  logic [7:0]  flit_length_o, flit_address_o;
  logic        empty_o, full_o, overflow_o, underflow_o;
  logic [3:0]  count_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  flit_buffer #(.DEPTH(8), .FLIT_WIDTH(32), .ADD_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push_i),
    .flit_i         (flit_i),
    .pop_i          (pop_i),
    .flit_o         (flit_o),
    .data_valid_o   (data_valid_o),
    .flit_length_o  (flit_length_o),
    .flit_address_o (flit_address_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycle(input logic push, input logic [31:0] flit, input logic pop);
    push_i = push;
    flit_i = flit;
    pop_i  = pop;
    @(posedge clk);
    #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
    flit_i = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
    check({tag, "_full"},  32'(full_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_dv"},    32'(data_valid_o), 32'd0);
    check({tag, "_flit"},  flit_o, 32'd0);
    check({tag, "_len"},   32'(flit_length_o), 32'd0);
    check({tag, "_addr"},  32'(flit_address_o), 32'd0);
    check({tag, "_ovf"},   32'(overflow_o), 32'd0);
    check({tag, "_unf"},   32'(underflow_o), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; push_i = 1'b0; pop_i = 1'b0; flit_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("rst");

    // Packet: header len 3 addr 5, three payload flits
    cycle(1'b1, 32'h0000_0305, 1'b0);
    check("p1_dv1", 32'(data_valid_o), 32'd1);
    check("p1_cnt1", 32'(count_o), 32'd1);
    cycle(1'b1, 32'h0000_00A1, 1'b0);
    cycle(1'b1, 32'h0000_00A2, 1'b0);
    cycle(1'b1, 32'h0000_00A3, 1'b0);
    check("p1_cnt4", 32'(count_o), 32'd4);
    check("p1_dv", 32'(data_valid_o), 32'd1);
    check("p1_len", 32'(flit_length_o), 32'd3);
    check("p1_addr", 32'(flit_address_o), 32'h05);
    check("p1_flit", flit_o, 32'h0000_0305);
    cycle(1'b0, '0, 1'b1);
    check("p1_pl1_flit", flit_o, 32'h0000_00A1);
    check("p1_pl1_dv", 32'(data_valid_o), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check("p1_pl2_flit", flit_o, 32'h0000_00A2);
    check("p1_pl2_dv", 32'(data_valid_o), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check("p1_pl3_flit", flit_o, 32'h0000_00A3);
    check("p1_pl3_dv", 32'(data_valid_o), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check("p1_empty", 32'(empty_o), 32'd1);
    check("p1_empty_flit", flit_o, 32'd0);

    // Zero-length header followed directly by another header
    cycle(1'b1, 32'h0000_0011, 1'b0);
    cycle(1'b1, 32'h0000_0122, 1'b0);
    check("z_dv", 32'(data_valid_o), 32'd1);
    check("z_addr", 32'(flit_address_o), 32'h11);
    check("z_len", 32'(flit_length_o), 32'd0);
    cycle(1'b1, 32'h0000_00B0, 1'b1);
    check("z2_dv", 32'(data_valid_o), 32'd1);
    check("z2_addr", 32'(flit_address_o), 32'h22);
    check("z2_len", 32'(flit_length_o), 32'd1);
    cycle(1'b0, '0, 1'b1);
    check("z2_pl_flit", flit_o, 32'h0000_00B0);
    check("z2_pl_dv", 32'(data_valid_o), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check("z_drained", 32'(count_o), 32'd0);

    // Fill to full, dropped push, push+pop while full
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h0000_0040 + 32'(i), 1'b0);
    check("f_full", 32'(full_o), 32'd1);
    check("f_cnt8", 32'(count_o), 32'd8);
    check("f_ovf0", 32'(overflow_o), 32'd0);
    cycle(1'b1, 32'h0000_0599, 1'b0);
    check("f_drop_cnt", 32'(count_o), 32'd8);
    check("f_ovf", 32'(overflow_o), 32'd1);
    check("f_head", flit_o, 32'h0000_0040);
    cycle(1'b1, 32'h0000_0598, 1'b1);
    check("f_pp_cnt", 32'(count_o), 32'd7);
    check("f_pp_full", 32'(full_o), 32'd0);
    for (int i = 1; i < 8; i++) begin
      check("f_order", flit_o, 32'h0000_0040 + 32'(i));
      check("f_order_dv", 32'(data_valid_o), 32'd1);
      cycle(1'b0, '0, 1'b1);
    end
    check("f_drained", 32'(empty_o), 32'd1);

    // Pop while empty
    check("u_unf0", 32'(underflow_o), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check("u_unf", 32'(underflow_o), 32'd1);
    check("u_cnt", 32'(count_o), 32'd0);
    check("u_empty", 32'(empty_o), 32'd1);
    check("u_ovf_sticky", 32'(overflow_o), 32'd1);
    // Dropped length-5 push must not have advanced the framer
    cycle(1'b1, 32'h0000_0055, 1'b0);
    check("u_hdr_dv", 32'(data_valid_o), 32'd1);
    check("u_hdr_flit", flit_o, 32'h0000_0055);

    // Streaming push+pop every cycle, wrapping pointers
    for (int i = 0; i < 20; i++) begin
      v = 32'hC000_0000 | 32'(i);
      cycle(1'b1, v, 1'b1);
      check("s_flit", flit_o, v);
      check("s_cnt", 32'(count_o), 32'd1);
      check("s_dv", 32'(data_valid_o), 32'd1);
    end
    cycle(1'b0, '0, 1'b1);
    check("s_empty", 32'(empty_o), 32'd1);

    // Reset mid-packet
    cycle(1'b1, 32'h0000_0402, 1'b0);
    cycle(1'b1, 32'h0000_00D1, 1'b0);
    check("r_pre_cnt", 32'(count_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_reset_state("r_async");
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("r_after");
    cycle(1'b1, 32'h0000_0207, 1'b0);
    check("r_dv", 32'(data_valid_o), 32'd1);
    check("r_len", 32'(flit_length_o), 32'd2);
    check("r_addr", 32'(flit_address_o), 32'h07);
    cycle(1'b1, 32'h0000_00E1, 1'b1);
    check("r_pl_flit", flit_o, 32'h0000_00E1);
    check("r_pl_dv", 32'(data_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
